// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_pkg - shared convolutional-code constants, FSM states, parity helper | Rev 1.0
// ----------------------------------------------------------------------------
package conv_pkg;

  localparam int MAX_K     = 9;
  localparam int MAX_N     = 3;
  localparam int MAX_PUNCT = 8;
  localparam int PHASE_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    TAIL  = 2'd2,
    DRAIN = 2'd3
  } enc_state_e;

  // Parity of the tapped register bits; taps at or above K do not exist for this code.
  function automatic logic conv_parity(input logic [MAX_K-1:0] poly,
                                       input logic [MAX_K-1:0] sreg,
                                       input logic [3:0]       k);
    logic [MAX_K-1:0] kmask;
    kmask = '0;
    for (int i = 0; i < MAX_K; i++) begin
      kmask[i] = (i < int'(k));
    end
    return ^(sreg & poly & kmask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_punct_phase.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_punct_phase - wrapping puncture phase counter and pattern column select | Rev 1.0
// ----------------------------------------------------------------------------
module conv_punct_phase
  import conv_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            advance,
  input  logic [PHASE_W-1:0]              period,
  input  logic [MAX_N-1:0][MAX_PUNCT-1:0] pat,
  output logic [MAX_N-1:0]                column
);

  logic [PHASE_W-1:0] phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (advance) begin
      phase <= (phase == period) ? '0 : phase + 3'd1;
    end
  end

  for (genvar n = 0; n < MAX_N; n++) begin : g_col
    assign column[n] = pat[n][phase];
  end

endmodule
`default_nettype wire

// File: rtl/conv_encoder_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_encoder_stream - streaming rate-1/N convolutional encoder, puncture mask, zero tail | Rev 1.0
// ----------------------------------------------------------------------------
module conv_encoder_stream
  import conv_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_start,
  input  logic [MAX_N-1:0][MAX_K-1:0]     i_gen_poly,
  input  logic [1:0]                      i_code_n,
  input  logic [3:0]                      i_k,
  input  logic [MAX_N-1:0][MAX_PUNCT-1:0] i_punct_pat,
  input  logic [2:0]                      i_punct_period,
  input  logic                            i_tail_en,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic                            i_data,
  input  logic                            i_last,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [MAX_N-1:0]                o_sym,
  output logic [MAX_N-1:0]                o_mask,
  output logic                            o_last,
  output logic                            o_busy,
  output logic                            o_done
);

  enc_state_e fsm, fsm_next;

  logic [1:0]                      code_n_cfg;
  logic [3:0]                      k_cfg;
  logic [MAX_N-1:0][MAX_K-1:0]     poly_cfg;
  logic [MAX_N-1:0][MAX_PUNCT-1:0] pat_cfg;
  logic [2:0]                      period_cfg;
  logic                            tail_cfg;

  logic [MAX_K-2:0] shreg;
  logic [3:0]       tail_cnt;

  logic             out_free, run_fire, tail_fire, fire, start_ok, in_bit, last_next;
  logic [MAX_K-1:0] sreg;
  logic [MAX_K-2:0] state_mask;
  logic [MAX_N-1:0] n_mask, sym_next, punct_col;

  assign o_busy    = (fsm != IDLE) || o_valid;
  assign out_free  = !o_valid || i_ready;
  assign o_ready   = (fsm == RUN) && out_free;
  assign run_fire  = o_ready && i_valid;
  assign tail_fire = (fsm == TAIL) && out_free;
  assign fire      = run_fire || tail_fire;
  assign start_ok  = i_start && !o_busy;
  // Tail symbols shift in zeros.
  assign in_bit    = run_fire && i_data;
  assign sreg      = {shreg, in_bit};
  assign last_next = run_fire ? (i_last && !tail_cfg) : (tail_cnt == 4'd0);

  always_comb begin
    n_mask     = '0;
    state_mask = '0;
    sym_next   = '0;
    for (int n = 0; n < MAX_N; n++) begin
      n_mask[n] = (n < int'(code_n_cfg));
    end
    for (int i = 0; i < MAX_K - 1; i++) begin
      state_mask[i] = ((i + 1) < int'(k_cfg));
    end
    for (int g = 0; g < MAX_N; g++) begin
      sym_next[g] = conv_parity(poly_cfg[g], sreg, k_cfg) && n_mask[g];
    end
  end

  conv_punct_phase u_phase (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .advance (fire),
    .period  (period_cfg),
    .pat     (pat_cfg),
    .column  (punct_col)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (start_ok) fsm_next = RUN;
      RUN:     if (run_fire && i_last) fsm_next = tail_cfg ? TAIL : DRAIN;
      TAIL:    if (tail_fire && (tail_cnt == 4'd0)) fsm_next = DRAIN;
      DRAIN:   if (o_valid && i_ready && o_last) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_n_cfg <= '0;
      k_cfg      <= '0;
      poly_cfg   <= '0;
      pat_cfg    <= '0;
      period_cfg <= '0;
      tail_cfg   <= 1'b0;
      shreg      <= '0;
      tail_cnt   <= '0;
      o_valid    <= 1'b0;
      o_sym      <= '0;
      o_mask     <= '0;
      o_last     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      if (start_ok) begin
        code_n_cfg <= i_code_n;
        k_cfg      <= i_k;
        poly_cfg   <= i_gen_poly;
        pat_cfg    <= i_punct_pat;
        period_cfg <= i_punct_period;
        tail_cfg   <= i_tail_en;
        shreg      <= '0;
      end
      // K-1 tail symbols: count K-2 down to 0.
      if (run_fire && i_last && tail_cfg) begin
        tail_cnt <= k_cfg - 4'd2;
      end else if (tail_fire) begin
        tail_cnt <= tail_cnt - 4'd1;
      end
      if (fire) begin
        shreg   <= {shreg[MAX_K-3:0], in_bit} & state_mask;
        o_valid <= 1'b1;
        o_sym   <= sym_next;
        o_mask  <= punct_col & n_mask;
        o_last  <= last_next;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_sym   <= '0;
        o_mask  <= '0;
        o_last  <= 1'b0;
      end
      o_done <= o_valid && i_ready && o_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_stream.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_encoder_stream - directed and random checks against a tap-sum reference model | Rev 1.0
// ----------------------------------------------------------------------------
module tb_conv_encoder_stream;
  import conv_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            i_start = 1'b0;
  logic [MAX_N-1:0][MAX_K-1:0]     i_gen_poly = '0;
  logic [1:0]                      i_code_n = '0;
  logic [3:0]                      i_k = '0;
  logic [MAX_N-1:0][MAX_PUNCT-1:0] i_punct_pat = '0;
  logic [2:0]                      i_punct_period = '0;
  logic                            i_tail_en = 1'b0;
  logic                            i_valid = 1'b0;
  logic                            i_data = 1'b0;
  logic                            i_last = 1'b0;
  logic                            i_ready = 1'b1;
  logic                            o_ready, o_valid, o_last, o_busy, o_done;
  logic [MAX_N-1:0]                o_sym, o_mask;

  conv_encoder_stream dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_gen_poly(i_gen_poly),
    .i_code_n(i_code_n), .i_k(i_k), .i_punct_pat(i_punct_pat),
    .i_punct_period(i_punct_period), .i_tail_en(i_tail_en), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_last(i_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_sym(o_sym), .o_mask(o_mask), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int ready_mode = 0;
  int done_cnt = 0;
  int frames = 0;
  logic prev_last_hs = 1'b0;

  int cfg_k, cfg_n, cfg_period;
  logic cfg_tail;
  logic [MAX_N-1:0][MAX_K-1:0]     cfg_poly;
  logic [MAX_N-1:0][MAX_PUNCT-1:0] cfg_pat;

  logic       data_q[$];
  logic [6:0] exp_q[$], got_q[$], fix_q[$], t1_ref[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output collector and o_done-follows-last-handshake check.
  always @(negedge clk) begin
    if (rst) begin
      prev_last_hs <= 1'b0;
    end else begin
      check("o_done_timing", 32'(o_done), 32'(prev_last_hs));
      if (o_done) done_cnt <= done_cnt + 1;
      if (o_valid && i_ready) got_q.push_back({o_sym, o_mask, o_last});
      prev_last_hs <= o_valid && i_ready && o_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       i_ready = ~i_ready;
      2:       i_ready = ($urandom_range(3) != 0);
      default: i_ready = 1'b1;
    endcase
  endtask

  // Reference: each coded bit is the XOR of the input bits delayed by every tapped d < K.
  task automatic build_expected();
    logic bits[$];
    int   total;
    exp_q.delete();
    bits = data_q;
    if (cfg_tail) for (int i = 0; i < cfg_k - 1; i++) bits.push_back(1'b0);
    total = bits.size();
    for (int j = 0; j < total; j++) begin
      logic [2:0] s, m;
      s = '0;
      m = '0;
      for (int n = 0; n < cfg_n; n++) begin
        for (int d = 0; d < cfg_k; d++)
          if (j - d >= 0 && cfg_poly[n][d]) s[n] = s[n] ^ bits[j - d];
        m[n] = cfg_pat[n][j % (cfg_period + 1)];
      end
      exp_q.push_back({s, m, (j == total - 1)});
    end
  endtask

  task automatic start_frame();
    i_gen_poly     = cfg_poly;
    i_code_n       = 2'(cfg_n);
    i_k            = 4'(cfg_k);
    i_punct_pat    = cfg_pat;
    i_punct_period = 3'(cfg_period);
    i_tail_en      = cfg_tail;
    i_start        = 1'b1;
    step();
    i_start        = 1'b0;
    got_q.delete();
  endtask

  task automatic send_frame(input int gap_pct, input bit inject);
    logic hs;
    int   guard;
    for (int b = 0; b < data_q.size(); b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        i_valid = 1'b0;
        step();
      end
      i_valid = 1'b1;
      i_data  = data_q[b];
      i_last  = (b == data_q.size() - 1);
      if (inject && b == data_q.size() / 2) begin
        i_start = 1'b1;
        i_k     = 4'd3;
        i_gen_poly = '1;
      end
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 1000) begin
        @(negedge clk);
        hs = o_ready;
        step();
        guard++;
      end
      i_start = 1'b0;
      if (!hs) begin
        check("ready_timeout", 32'(hs), 32'd1);
        i_valid = 1'b0;
        return;
      end
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    frames++;
    while (done_cnt < frames && g < 5000) begin
      step();
      g++;
    end
    check("done_seen", 32'(done_cnt >= frames), 32'd1);
    check("busy_after_done", 32'(o_busy), 32'd0);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_sym"},  32'(got_q[i][6:4]), 32'(exp_q[i][6:4]));
      check({tag, "_mask"}, 32'(got_q[i][3:1]), 32'(exp_q[i][3:1]));
      check({tag, "_last"}, 32'(got_q[i][0]),   32'(exp_q[i][0]));
    end
  endtask

  task automatic check_fixed(input string tag);
    check({tag, "_count"}, got_q.size(), fix_q.size());
    for (int i = 0; i < got_q.size() && i < fix_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(fix_q[i]));
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input bit inject);
    build_expected();
    start_frame();
    send_frame(gap_pct, inject);
    wait_done();
    compare_frame(tag);
  endtask

  task automatic set_t1_cfg();
    cfg_k = 3; cfg_n = 2; cfg_tail = 1'b1; cfg_period = 0;
    cfg_poly[0] = 9'o607;   // taps above K must be ignored
    cfg_poly[1] = 9'o405;
    cfg_poly[2] = 9'o777;   // unused generator must produce 0
    cfg_pat = '1;
    data_q = '{1'b1, 1'b0, 1'b1, 1'b1};
  endtask

  initial begin
    // {sym[2:0], mask[2:0], last}: sym 11,10,00,01 then tail 01,11 (bit0 first)
    t1_ref = '{{3'b011, 3'b011, 1'b0}, {3'b001, 3'b011, 1'b0}, {3'b000, 3'b011, 1'b0},
               {3'b010, 3'b011, 1'b0}, {3'b010, 3'b011, 1'b0}, {3'b011, 3'b011, 1'b1}};

    #12;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_sym",   32'(o_sym),   0);
    check("rst_busy",  32'(o_busy),  0);
    check("rst_ready", 32'(o_ready), 0);
    step();
    rst = 1'b0;
    step();

    set_t1_cfg();
    ready_mode = 0;
    run_frame("t1_tail", 0, 1'b0);
    fix_q = t1_ref;
    check_fixed("t1_fixed");

    cfg_tail = 1'b0;
    run_frame("t2_notail", 0, 1'b0);
    fix_q = '{t1_ref[0], t1_ref[1], t1_ref[2], {3'b010, 3'b011, 1'b1}};
    check_fixed("t2_fixed");

    cfg_tail = 1'b1; cfg_period = 1;
    cfg_pat[0] = 8'h03; cfg_pat[1] = 8'h01; cfg_pat[2] = 8'hFF;
    run_frame("t3_punct", 0, 1'b0);
    fix_q = '{{3'b011, 3'b011, 1'b0}, {3'b001, 3'b001, 1'b0}, {3'b000, 3'b011, 1'b0},
              {3'b010, 3'b001, 1'b0}, {3'b010, 3'b011, 1'b0}, {3'b011, 3'b001, 1'b1}};
    check_fixed("t3_fixed");

    set_t1_cfg();
    ready_mode = 1;
    run_frame("t4_toggle", 0, 1'b0);
    fix_q = t1_ref;
    check_fixed("t4_fixed");

    cfg_k = 7; cfg_n = 3; cfg_tail = 1'b1;
    cfg_poly[0] = 9'o133; cfg_poly[1] = 9'o171; cfg_poly[2] = 9'o165;
    cfg_period = $urandom_range(7);
    for (int n = 0; n < MAX_N; n++) cfg_pat[n] = 8'($urandom);
    data_q.delete();
    for (int i = 0; i < 1000; i++) data_q.push_back(1'($urandom));
    ready_mode = 2;
    run_frame("t5_k7", 20, 1'b1);

    cfg_k = 9; cfg_n = 3; cfg_tail = 1'b1; cfg_period = 2;
    for (int n = 0; n < MAX_N; n++) cfg_poly[n] = 9'($urandom) | 9'h101;
    data_q = '{1'b1};
    ready_mode = 1;
    run_frame("t6_single", 0, 1'b0);

    cfg_k = 5; cfg_n = 2; cfg_tail = 1'b0; cfg_period = $urandom_range(7);
    for (int n = 0; n < MAX_N; n++) cfg_poly[n] = 9'($urandom);
    data_q.delete();
    for (int i = 0; i < 60; i++) data_q.push_back(1'($urandom));
    ready_mode = 2;
    run_frame("t7_k5", 30, 1'b0);

    set_t1_cfg();
    ready_mode = 0;
    start_frame();
    i_valid = 1'b1; i_data = 1'b1; i_last = 1'b0;
    step();
    step();
    check("pre_rst_busy", 32'(o_busy), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_sym",   32'(o_sym),   0);
    check("midrst_mask",  32'(o_mask),  0);
    check("midrst_last",  32'(o_last),  0);
    check("midrst_busy",  32'(o_busy),  0);
    check("midrst_ready", 32'(o_ready), 0);
    check("midrst_done",  32'(o_done),  0);
    i_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    set_t1_cfg();
    run_frame("t9_after_rst", 0, 1'b0);
    fix_q = t1_ref;
    check_fixed("t9_fixed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
